// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and sizing helpers for the sequential multiplier
//
// Purpose: FSM state encoding and the iteration-counter width used by seq_multiplier.
// Contents:
//   state_t         IDLE / BUSY / DONE control states
//   DEFAULT_WIDTH   default operand width
//   cnt_width()     iteration counter width, $clog2(width)

package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice (WIDTH >= 2).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// rtl/seq_mult_datapath.sv - shift-add datapath for the sequential multiplier
//
// Purpose: holds the multiplicand, the 2*WIDTH+1 bit accumulator (carry included) and the
// registered product; performs one partial-product add-and-shift per step strobe.
// Optional macro SEQ_MULT_SIGNED_EN adds magnitude capture and final negation.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          capture operands, clear upper accumulator half
//   step_i          one add-and-shift iteration
//   finish_i        last iteration: write (possibly negated) result into product_o
//   a_i, b_i        multiplicand, multiplier
//   op_signed_i     two's-complement mode (SEQ_MULT_SIGNED_EN only)
//   product_o       registered 2*WIDTH-bit product

module seq_mult_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               finish_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               op_signed_i,
`endif
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_step;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   mag_a, mag_b;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
  always_comb begin
    mag_a  = (op_signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
    mag_b  = (op_signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
    sign_d = sign_q;
    if (load_i) sign_d = op_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    result = sign_q ? (~acc_step[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc_step[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sign_q <= 1'b0;
    else        sign_q <= sign_d;
  end
`else
  always_comb begin
    mag_a  = a_i;
    mag_b  = b_i;
    result = acc_step[2*WIDTH-1:0];
  end
`endif

  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    // Multiplier bits sit in the low half and are consumed LSB first; the carry bit of
    // the upper-half sum shifts down so nothing is ever lost.
    upper_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step  = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
    if (load_i) begin
      mcand_d = mag_a;
      acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
    end else if (step_i) begin
      acc_d = acc_step;
    end
    if (finish_i) product_d = result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier with valid/ready handshakes
//
// Purpose: accepts one operand pair in IDLE, spends WIDTH cycles in BUSY (one partial
// product per clock), then presents the 2*WIDTH-bit product in DONE until taken.
// Optional macro SEQ_MULT_SIGNED_EN adds the op_signed port (two's-complement mode).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                  multiplicand, multiplier (sampled at accept only)
//   op_signed             two's-complement select (SEQ_MULT_SIGNED_EN only)
//   out_valid / out_ready product handshake (out_valid high only in DONE)
//   product               result, stable while out_valid

module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               op_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load, step, finish;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step    = 1'b1;
        count_d = count_q + CNT_W'(1);
        // count_q == WIDTH-1 marks the WIDTH-th iteration.
        if (count_q == LAST) begin
          finish  = 1'b1;
          count_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .step_i      (step),
    .finish_i    (finish),
    .a_i         (a),
    .b_i         (b),
`ifdef SEQ_MULT_SIGNED_EN
    .op_signed_i (op_signed),
`endif
    .product_o   (product)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier (WIDTH=4 and WIDTH=8)

module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, op_signed4;
  logic [3:0] a4, b4;
  logic [7:0] product4;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, op_signed8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp4[$];
  logic [15:0] exp8[$];

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4),
`ifdef SEQ_MULT_SIGNED_EN
    .op_signed(op_signed4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .product(product4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8),
`ifdef SEQ_MULT_SIGNED_EN
    .op_signed(op_signed8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
  );

  function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y, input logic s);
    int sx, sy;
    if (s) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'(x);
      sy = int'(y);
    end
    return 8'(sx * sy);
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
    return 16'(int'(x) * int'(y));
  endfunction

  task automatic issue4(input logic [3:0] x, input logic [3:0] y, input logic s);
    @(negedge clk);
    a4 = x; b4 = y; op_signed4 = s; in_valid4 = 1'b1;
    exp4.push_back(model4(x, y, s));
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a8 = x; b8 = y; in_valid8 = 1'b1;
    exp8.push_back(model8(x, y));
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  task automatic wait_out4(output int lat, output bit ready_seen);
    lat = -1; ready_seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (in_ready4) ready_seen = 1'b1;
      if (out_valid4) begin lat = n; break; end
    end
  endtask

  task automatic wait_out8(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (out_valid8) begin lat = n; break; end
    end
  endtask

  task automatic release4();
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic release8();
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || product4 !== 8'd0) begin
      errors++;
      $display("FAIL reset4: in_ready=%b out_valid=%b product=%0d, required 1 0 0", in_ready4, out_valid4, product4);
    end
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || product8 !== 16'd0) begin
      errors++;
      $display("FAIL reset8: in_ready=%b out_valid=%b product=%0d, required 1 0 0", in_ready8, out_valid8, product8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b, required 1 0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_basic();
    logic [3:0] ta[3] = '{4'd1, 4'd15, 4'd0};
    logic [3:0] tb[3] = '{4'd3, 4'd15, 4'd13};
    int lat; bit rs; logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      issue4(ta[i], tb[i], 1'b0);
      wait_out4(lat, rs);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL basic_latency %0d*%0d: got %0d cycles, required 4", ta[i], tb[i], lat); end
      checks++;
      if (rs) begin errors++; $display("FAIL basic_in_ready %0d*%0d: in_ready=1 seen during BUSY/DONE, required 0", ta[i], tb[i]); end
      e = exp4.pop_front();
      checks++;
      if (product4 !== e) begin errors++; $display("FAIL basic_product %0d*%0d: got %0d, required %0d", ta[i], tb[i], product4, e); end
      release4();
      checks++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
        errors++; $display("FAIL basic_return_idle: out_valid=%b in_ready=%b, required 0 1", out_valid4, in_ready4);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; bit rs; logic [7:0] e;
    issue4(4'd9, 4'd5, 1'b0);
    wait_out4(lat, rs);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d, required 4", lat); end
    e = exp4.pop_front();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_valid4 !== 1'b1 || product4 !== e || in_ready4 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b product=%0d in_ready=%b, required 1 %0d 0", k, out_valid4, product4, in_ready4, e);
      end
      @(negedge clk);
    end
    release4();
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid4, in_ready4);
    end
  endtask

  task automatic test_disturb();
    int lat; bit rs; logic [7:0] e;
    issue4(4'd10, 4'd6, 1'b0);
    a4 = 4'd15; b4 = 4'd15; in_valid4 = 1'b1;
    wait_out4(lat, rs);
    in_valid4 = 1'b0;
    checks++;
    if (lat !== 4 || rs) begin errors++; $display("FAIL disturb_timing: latency %0d ready_seen %0d, required 4 0", lat, rs); end
    e = exp4.pop_front();
    checks++;
    if (product4 !== e) begin errors++; $display("FAIL disturb_product: got %0d, required %0d", product4, e); end
    release4();
    checks++;
    if (exp4.size() != 0 || in_ready4 !== 1'b1) begin
      errors++; $display("FAIL disturb_extra_accept: pending %0d in_ready=%b, required 0 1", exp4.size(), in_ready4);
    end
  endtask

  task automatic test_reset_midop();
    int lat; bit rs; logic [7:0] e;
    issue4(4'd12, 4'd3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid4 !== 1'b0 || product4 !== 8'd0 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: out_valid=%b product=%0d in_ready=%b, required 0 0 1", out_valid4, product4, in_ready4);
    end
    exp4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue4(4'd7, 4'd7, 1'b0);
    wait_out4(lat, rs);
    e = exp4.pop_front();
    checks++;
    if (lat !== 4 || product4 !== e) begin
      errors++; $display("FAIL midop_next_op: latency %0d product %0d, required 4 %0d", lat, product4, e);
    end
    release4();
  endtask

  task automatic test_back_to_back();
    int acc_t[3]; int nacc = 0; int nout = 0; logic [7:0] e;
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; op_signed4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
    for (int cyc = 0; cyc < 80 && nout < 3; cyc++) begin
      if (in_valid4 && in_ready4) begin
        exp4.push_back(model4(a4, b4, 1'b0));
        acc_t[nacc] = cyc;
        nacc++;
      end
      if (out_valid4 && out_ready4) begin
        e = exp4.pop_front();
        checks++;
        if (product4 !== e) begin errors++; $display("FAIL b2b_product %0d: got %0d, required %0d", nout, product4, e); end
        nout++;
      end
      @(negedge clk);
      if (nacc >= 3) in_valid4 = 1'b0;
    end
    out_ready4 = 1'b0;
    in_valid4 = 1'b0;
    checks++;
    if (nout != 3 || nacc != 3) begin errors++; $display("FAIL b2b_count: %0d accepts %0d outputs, required 3 3", nacc, nout); end
    else begin
      checks++;
      if (acc_t[1] - acc_t[0] != 6 || acc_t[2] - acc_t[1] != 6) begin
        errors++; $display("FAIL b2b_spacing: %0d and %0d cycles, required 6", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
      end
    end
  endtask

  task automatic test_sweep8();
    logic [7:0] xa[6] = '{8'd255, 8'd0, 8'd255, 8'd1, 8'd128, 8'd0};
    logic [7:0] xb[6] = '{8'd255, 8'd0, 8'd1, 8'd255, 8'd128, 8'd255};
    logic [7:0] x, y; logic [15:0] e; int lat;
    for (int i = 0; i < 1206; i++) begin
      if (i < 6) begin x = xa[i]; y = xb[i]; end
      else begin x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255)); end
      issue8(x, y);
      wait_out8(lat);
      e = exp8.pop_front();
      checks++;
      if (lat !== 8 || product8 !== e) begin
        errors++; $display("FAIL w8_product %0d*%0d: latency %0d product %0d, required 8 %0d", x, y, lat, product8, e);
      end
      release8();
    end
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed();
    logic [3:0] sa[5] = '{4'h8, 4'h8, 4'h8, 4'h7, 4'h0};
    logic [3:0] sb[5] = '{4'h7, 4'h8, 4'h7, 4'hF, 4'h8};
    logic       ss[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int lat; bit rs; logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      issue4(sa[i], sb[i], ss[i]);
      wait_out4(lat, rs);
      e = exp4.pop_front();
      checks++;
      if (lat !== 4 || product4 !== e) begin
        errors++; $display("FAIL signed %h*%h s=%0d: latency %0d product %h, required 4 %h", sa[i], sb[i], ss[i], lat, product4, e);
      end
      release4();
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; op_signed4 = 1'b0; a4 = '0; b4 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op_signed8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_disturb();
    test_reset_midop();
    test_back_to_back();
    test_sweep8();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
